// File: rtl/piarb_fid_dispatch_if.sv
// Bus between the flow-ID dispatcher, the descriptor ingress FIFO, the piarb
// flow-ID table and the PU queues.
interface piarb_fid_dispatch_if #(
    parameter int ID_NBITS    = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter int FID_NBITS   = 8
);
    // Descriptor handshake: a descriptor transfers on a rising clk edge where
    // desc_valid & desc_ready; the offerer must hold desc_valid/desc_fid stable until then.
    logic                        desc_valid;
    logic [FID_NBITS-1:0]        desc_fid;
    logic                        desc_ready;

    logic                        fid_lookup_req;
    logic [FID_NBITS-1:0]        fid_lookup_fid;
    logic                        fid_lookup_ack;
    logic [QUEUE_DEPTH-1:0][1:0] fid_lookup_fid_valid;
    logic [QUEUE_DEPTH-1:0][1:0] fid_lookup_fid_hit;
    logic [QUEUE_DEPTH-1:0]      pu_avail;

    logic                        wr_fid_req;
    logic [FID_NBITS-1:0]        wr_fid;
    logic [QUEUE_DEPTH-1:0]      wr_fid_sel_id;
    logic                        wr_fid_sel;

    logic                        enq_req;
    logic [ID_NBITS-1:0]         enq_qid;
    logic                        enq_fid_sel;

    modport master (
        input  desc_valid, desc_fid, fid_lookup_ack, fid_lookup_fid_valid,
               fid_lookup_fid_hit, pu_avail,
        output desc_ready, fid_lookup_req, fid_lookup_fid, wr_fid_req, wr_fid,
               wr_fid_sel_id, wr_fid_sel, enq_req, enq_qid, enq_fid_sel
    );

    modport slave (
        output desc_valid, desc_fid, fid_lookup_ack, fid_lookup_fid_valid,
               fid_lookup_fid_hit, pu_avail,
        input  desc_ready, fid_lookup_req, fid_lookup_fid, wr_fid_req, wr_fid,
               wr_fid_sel_id, wr_fid_sel, enq_req, enq_qid, enq_fid_sel
    );
endinterface

// File: rtl/piarb_fid_dispatch.sv
// Flow-ID dispatcher: looks each descriptor's FID up in the piarb table, keeps
// flow affinity on a hit, allocates a free slot round-robin on a miss, then enqueues.
module piarb_fid_dispatch #(
    parameter int ID_NBITS    = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter int FID_NBITS   = 8
) (
    input  logic                clk,
    input  logic                rst,
    piarb_fid_dispatch_if.master bus,
    output logic [31:0]         dispatch_cnt_o,
    output logic [15:0]         stall_cnt_o,
    output logic                ack_err_o,
    output logic [2:0]          state_o,
    output logic [ID_NBITS-1:0] rr_ptr_o
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOOKUP = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] ISSUE  = 3'd3;
    localparam logic [2:0] RETRY  = 3'd4;

    localparam logic [ID_NBITS-1:0] LAST_ID = ID_NBITS'(QUEUE_DEPTH - 1);
    localparam logic [ID_NBITS:0]   QD_W    = (ID_NBITS + 1)'(QUEUE_DEPTH);

    logic [2:0]           state_q, state_d;
    logic [FID_NBITS-1:0] fid_q, fid_d;
    logic [ID_NBITS-1:0]  qid_q, qid_d;
    logic                 sel_q, sel_d;
    logic                 miss_q, miss_d;
    logic [ID_NBITS-1:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0]          dispatch_cnt_q, dispatch_cnt_d;
    logic [15:0]          stall_cnt_q, stall_cnt_d;
    logic                 ack_err_q, ack_err_d;

    logic                 hit_any;
    logic [ID_NBITS-1:0]  hit_qid;
    logic                 hit_sel;
    logic                 cand_found;
    logic [ID_NBITS-1:0]  cand_qid;
    logic                 cand_sel;
    logic [ID_NBITS:0]    scan_idx;
    logic [ID_NBITS-1:0]  scan_id;
    logic                 issue;

    // The table guarantees at most one hit, so the last match found is the only one.
    always_comb begin
        hit_any = 1'b0;
        hit_qid = '0;
        hit_sel = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            for (int s = 0; s < 2; s++) begin
                if (bus.fid_lookup_fid_hit[i][s]) begin
                    hit_any = 1'b1;
                    hit_qid = ID_NBITS'(i);
                    hit_sel = s[0];
                end
            end
        end
    end

    // Round-robin scan starting at rr_ptr; a PU qualifies if it can take an
    // entry and still has a free FID slot. Lowest free slot wins.
    always_comb begin
        cand_found = 1'b0;
        cand_qid   = '0;
        cand_sel   = 1'b0;
        scan_idx   = '0;
        scan_id    = '0;
        for (int k = 0; k < QUEUE_DEPTH; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (ID_NBITS + 1)'(k);
            if (scan_idx >= QD_W) begin
                scan_idx = scan_idx - QD_W;
            end
            scan_id = scan_idx[ID_NBITS-1:0];
            if (!cand_found && bus.pu_avail[scan_id] &&
                !(&bus.fid_lookup_fid_valid[scan_id])) begin
                cand_found = 1'b1;
                cand_qid   = scan_id;
                cand_sel   = bus.fid_lookup_fid_valid[scan_id][0];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        fid_d          = fid_q;
        qid_d          = qid_q;
        sel_d          = sel_q;
        miss_d         = miss_q;
        rr_ptr_d       = rr_ptr_q;
        dispatch_cnt_d = dispatch_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        ack_err_d      = ack_err_q;
        case (state_q)
            IDLE: begin
                if (bus.desc_valid) begin
                    fid_d   = bus.desc_fid;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: state_d = WAIT;
            WAIT: begin
                if (!bus.fid_lookup_ack) begin
                    ack_err_d = 1'b1;
                    state_d   = RETRY;
                end else if (hit_any) begin
                    qid_d   = hit_qid;
                    sel_d   = hit_sel;
                    miss_d  = 1'b0;
                    state_d = bus.pu_avail[hit_qid] ? ISSUE : RETRY;
                end else if (cand_found) begin
                    qid_d   = cand_qid;
                    sel_d   = cand_sel;
                    miss_d  = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = RETRY;
                end
            end
            ISSUE: begin
                dispatch_cnt_d = dispatch_cnt_q + 32'd1;
                if (miss_q) begin
                    rr_ptr_d = (qid_q == LAST_ID) ? '0 : qid_q + 1'b1;
                end
                // Returning through IDLE gives the table one cycle to update its counts.
                state_d = IDLE;
            end
            RETRY: begin
                if (stall_cnt_q != 16'hFFFF) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
                state_d = LOOKUP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            fid_q          <= '0;
            qid_q          <= '0;
            sel_q          <= 1'b0;
            miss_q         <= 1'b0;
            rr_ptr_q       <= '0;
            dispatch_cnt_q <= '0;
            stall_cnt_q    <= '0;
            ack_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            fid_q          <= fid_d;
            qid_q          <= qid_d;
            sel_q          <= sel_d;
            miss_q         <= miss_d;
            rr_ptr_q       <= rr_ptr_d;
            dispatch_cnt_q <= dispatch_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            ack_err_q      <= ack_err_d;
        end
    end

    assign issue = (state_q == ISSUE);

    // desc_ready is masked by reset so every output reads 0 while reset is held.
    assign bus.desc_ready     = (state_q == IDLE) & ~rst;
    assign bus.fid_lookup_req = (state_q == LOOKUP);
    assign bus.fid_lookup_fid = (state_q == IDLE) ? '0 : fid_q;
    assign bus.wr_fid_req     = issue & miss_q;
    assign bus.wr_fid         = bus.fid_lookup_fid;
    assign bus.wr_fid_sel_id  = (issue & miss_q) ? QUEUE_DEPTH'(qid_q) : '0;
    assign bus.wr_fid_sel     = issue & miss_q & sel_q;
    assign bus.enq_req        = issue;
    assign bus.enq_qid        = issue ? qid_q : '0;
    assign bus.enq_fid_sel    = issue & sel_q;

    assign dispatch_cnt_o = dispatch_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign ack_err_o      = ack_err_q;
    assign state_o        = state_q;
    assign rr_ptr_o       = rr_ptr_q;
endmodule
